gray_bin_conv_pipe: RTL

Parametrised, pipelined Gray/binary code converter with a valid/ready handshake on both sides. Each beat carries its own mode bit, so a single instance converts Gray-to-binary or binary-to-Gray per transaction. The prefix-XOR chain is split across STAGES register stages, which keeps wide words off the critical path. It sits between Gray-coded sources (counters, encoders, CDC pointers) and binary consumers, and also serves the reverse direction.

---
 rtl/gray_conv_pkg.sv | 14 +
 rtl/gray_bin_conv_pipe_if.sv | 23 ++
 rtl/gray_conv_stage.sv | 61 ++++++
 rtl/gray_bin_conv_pipe.sv | 69 ++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the pipelined Gray/binary converter.
package gray_conv_pkg;

    typedef enum logic {
        MODE_G2B = 1'b0,
        MODE_B2G = 1'b1
    } conv_mode_e;

    // Bits resolved per pipeline stage: ceil(width / stages).
    function automatic int seg_bits(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/gray_bin_conv_pipe_if.sv
// Valid/ready handshake bundle for both sides of the Gray/binary converter.
interface gray_bin_conv_pipe_if #(
    parameter int WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    gray_conv_pkg::conv_mode_e in_mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    gray_conv_pkg::conv_mode_e out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/gray_conv_stage.sv
// One pipeline slot: resolves Gray-to-binary bits HI..LO, and performs the
// whole binary-to-Gray conversion when it is the first slot (HI == WIDTH-1).
module gray_conv_stage
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LO    = 0,
    parameter int HI    = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  conv_mode_e       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output conv_mode_e       out_mode
);

    localparam bit FIRST = (HI == WIDTH - 1);

    logic [WIDTH-1:0] conv;
    logic             valid;

    always_comb begin
        conv = in_data;
        if (in_mode == MODE_B2G) begin
            if (FIRST) begin
                conv = in_data ^ (in_data >> 1);
            end
        end else begin
            // Walk downward so each bit sees its already-resolved upper neighbour;
            // bit HI+1 arrives resolved from the previous slot.
            for (int unsigned j = 1; j < WIDTH; j++) begin
                if (int'(WIDTH - 1 - j) >= LO && int'(WIDTH - 1 - j) <= HI) begin
                    conv[WIDTH-1-j] = conv[WIDTH-j] ^ in_data[WIDTH-1-j];
                end
            end
        end
    end

    assign in_ready  = !valid || out_ready;
    assign out_valid = valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            out_data <= '0;
            out_mode <= MODE_G2B;
        end else if (in_ready) begin
            valid <= in_valid;
            if (in_valid) begin
                out_data <= conv;
                out_mode <= in_mode;
            end
        end
    end

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined Gray<->binary converter: STAGES chained slots with per-beat mode
// and bubble-collapsing valid/ready flow control.
module gray_bin_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    gray_bin_conv_pipe_if.slave bus
);

    localparam int SEG = seg_bits(WIDTH, STAGES);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int HI = WIDTH - 1 - s * SEG;
        localparam int LO = (WIDTH - (s + 1) * SEG > 0) ? WIDTH - (s + 1) * SEG : 0;

        logic             valid;
        logic             ready;
        logic [WIDTH-1:0] data;
        conv_mode_e       mode;
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;
        conv_mode_e       prev_mode;
        logic             next_ready;

        if (s == 0) begin : g_head
            assign prev_valid = bus.in_valid;
            assign prev_data  = bus.in_data;
            assign prev_mode  = bus.in_mode;
        end else begin : g_body
            assign prev_valid = g_stage[s-1].valid;
            assign prev_data  = g_stage[s-1].data;
            assign prev_mode  = g_stage[s-1].mode;
        end

        // Ready ripples back from the output through each slot's own scope.
        if (s == STAGES - 1) begin : g_tail
            assign next_ready = bus.out_ready;
        end else begin : g_link
            assign next_ready = g_stage[s+1].ready;
        end

        gray_conv_stage #(
            .WIDTH (WIDTH),
            .LO    (LO),
            .HI    (HI)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (prev_valid),
            .in_ready  (ready),
            .in_data   (prev_data),
            .in_mode   (prev_mode),
            .out_valid (valid),
            .out_ready (next_ready),
            .out_data  (data),
            .out_mode  (mode)
        );
    end

    assign bus.in_ready  = g_stage[0].ready && !rst;
    assign bus.out_valid = g_stage[STAGES-1].valid;
    assign bus.out_data  = g_stage[STAGES-1].data;
    assign bus.out_mode  = g_stage[STAGES-1].mode;

endmodule
